uart_ram_bridge: RTL and testbench

- Parametrised successor to the SoC UART-to-RAM loader.
- Receives serial bytes, packs them into RAM words at an incrementing address, and on CPU request streams RAM words back out serially until it reads a zero word.
- Adds a baud divider with mid-bit sampling, a stop-bit check, configurable word size and memory map, and an idle timeout for partial words.
- Sits between the board UART pins and the shared SoC RAM port.

---
 rtl/uart_bridge_pkg.sv | 39 +++
 rtl/uart_baud_tick.sv | 37 +++
 rtl/uart_ram_bridge.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_ram_bridge.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bridge_pkg.sv
// ============================================================================
// uart_bridge_pkg : shared types and constants for uart_ram_bridge
// Optional parity framing is selected by UART_PARITY_CHECK_EN.  Revision 1.0
// ============================================================================
`default_nettype none

package uart_bridge_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_RX_START  = 4'd1,
    S_RX_DATA   = 4'd2,
    S_RX_STOP   = 4'd3,
    S_RX_WRITE  = 4'd4,
    S_TX_FETCH  = 4'd5,
    S_TX_BIT    = 4'd6,
    S_CLEAR     = 4'd7,
    S_EXCEPTION = 4'd8
  } state_t;

  localparam logic [7:0] EXC_STOP    = 8'd1;
  localparam logic [7:0] EXC_PARITY  = 8'd2;
  localparam logic [7:0] EXC_TIMEOUT = 8'd3;

  localparam int unsigned DEF_RX_BASE   = 206800;
  localparam int unsigned DEF_CTRL_ADDR = 411699;
  localparam int unsigned DEF_EXC_ADDR  = 411698;

`ifdef UART_PARITY_CHECK_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Bits sampled between start and stop: data plus optional parity.
  localparam int RX_BITS = FRAME_BITS - 2;

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// uart_baud_tick : bit-period counter with restart, mid-bit and end-bit pulses
// Revision 1.0
// ============================================================================
`default_nettype none

module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic half_tick,
  output logic full_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (cnt == CW'(CLKS_PER_BIT - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Restart lands one cycle into the bit, so the middle is CLKS_PER_BIT/2-1 counts later.
  assign half_tick = (cnt == CW'(CLKS_PER_BIT / 2 - 1));
  assign full_tick = (cnt == CW'(CLKS_PER_BIT - 1));

endmodule

`default_nettype wire

// File: rtl/uart_ram_bridge.sv
// ============================================================================
// uart_ram_bridge : packs received UART bytes into RAM words and streams RAM
// back out on CPU request; UART_PARITY_CHECK_EN adds even parity.  Rev 1.0
// ============================================================================
`default_nettype none

module uart_ram_bridge
  import uart_bridge_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 4,
  parameter int          WORD_BYTES   = 4,
  parameter int          ADDR_W       = 32,
  parameter int unsigned RX_BASE      = DEF_RX_BASE,
  parameter int unsigned CTRL_ADDR    = DEF_CTRL_ADDR,
  parameter int unsigned EXC_ADDR     = DEF_EXC_ADDR,
  parameter int          IDLE_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    datai,
  input  logic [8*WORD_BYTES-1:0] rramdata,
  output logic                    datao,
  output logic                    wram,
  output logic [ADDR_W-1:0]       ramaddress,
  output logic [8*WORD_BYTES-1:0] wramdata,
  output logic                    busy
);

  localparam int DW        = 8 * WORD_BYTES;
  localparam int BC_W      = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int TO_CYCLES = IDLE_TIMEOUT * CLKS_PER_BIT;
  localparam int TO_W      = $clog2(TO_CYCLES + 1);

  generate
    if (CLKS_PER_BIT < 2 || (CLKS_PER_BIT % 2) != 0) begin : g_cpb_check
      $error("CLKS_PER_BIT must be even and at least 2");
    end
  endgenerate

  state_t                  state;
  logic [ADDR_W-1:0]       rx_addr;
  logic [ADDR_W-1:0]       tx_addr;
  logic [BC_W-1:0]         byte_cnt;
  logic [DW-1:0]           word;
  logic [RX_BITS-1:0]      rx_shift;
  logic [FRAME_BITS-1:0]   tx_shift;
  logic [3:0]              bit_cnt;
  logic [TO_W-1:0]         idle_cnt;

  logic                    half_tick;
  logic                    full_tick;
  logic                    restart;
  logic                    ctrl_req;
  logic                    last_byte;
  logic [7:0]              rx_byte;
  logic [7:0]              tx_byte;
  logic [DW-1:0]           merged;
  logic [FRAME_BITS-1:0]   tx_frame;

  always_comb begin
    rx_byte   = rx_shift[7:0];
    // Byte 0 of a word is its most significant byte.
    tx_byte   = 8'(rramdata >> (8 * (WORD_BYTES - 1 - int'(byte_cnt))));
    merged    = DW'({word, rx_byte});
    last_byte = (byte_cnt == BC_W'(WORD_BYTES - 1));
    ctrl_req  = (rramdata == DW'(1));
`ifdef UART_PARITY_CHECK_EN
    tx_frame  = {1'b1, ^tx_byte, tx_byte, 1'b0};
`else
    tx_frame  = {1'b1, tx_byte, 1'b0};
`endif
  end

  assign restart = ((state == S_IDLE) && (ctrl_req || !datai)) || (state == S_TX_FETCH);
  assign busy    = (state != S_IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .rst       (rst),
    .restart   (restart),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

  // RAM-side outputs are registered, so each is set on the edge entering the state that owns it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      datao      <= 1'b1;
      wram       <= 1'b0;
      ramaddress <= ADDR_W'(CTRL_ADDR);
      wramdata   <= '0;
      rx_addr    <= ADDR_W'(RX_BASE);
      tx_addr    <= ADDR_W'(RX_BASE);
      byte_cnt   <= '0;
      word       <= '0;
      rx_shift   <= '0;
      tx_shift   <= '1;
      bit_cnt    <= '0;
      idle_cnt   <= '0;
    end else begin
      wram       <= 1'b0;
      ramaddress <= ADDR_W'(CTRL_ADDR);
      datao      <= 1'b1;
      idle_cnt   <= '0;

      case (state)
        S_IDLE: begin
          if (ctrl_req) begin
            state      <= S_TX_FETCH;
            tx_addr    <= ADDR_W'(RX_BASE);
            byte_cnt   <= '0;
            ramaddress <= ADDR_W'(RX_BASE);
          end else if (!datai) begin
            state <= S_RX_START;
          end else if (byte_cnt != '0) begin
            if (idle_cnt == TO_W'(TO_CYCLES - 1)) begin
              state      <= S_EXCEPTION;
              wram       <= 1'b1;
              ramaddress <= ADDR_W'(EXC_ADDR);
              wramdata   <= DW'(EXC_TIMEOUT);
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end

        S_RX_START: begin
          if (half_tick) begin
            if (datai) begin
              state <= S_IDLE;
            end else begin
              state   <= S_RX_DATA;
              bit_cnt <= '0;
            end
          end
        end

        S_RX_DATA: begin
          if (half_tick) begin
            rx_shift <= {datai, rx_shift[RX_BITS-1:1]};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == 4'(RX_BITS - 1)) begin
              state <= S_RX_STOP;
            end
          end
        end

        S_RX_STOP: begin
          if (half_tick) begin
            if (!datai) begin
              state      <= S_EXCEPTION;
              wram       <= 1'b1;
              ramaddress <= ADDR_W'(EXC_ADDR);
              wramdata   <= DW'(EXC_STOP);
`ifdef UART_PARITY_CHECK_EN
            end else if (^rx_shift) begin
              state      <= S_EXCEPTION;
              wram       <= 1'b1;
              ramaddress <= ADDR_W'(EXC_ADDR);
              wramdata   <= DW'(EXC_PARITY);
`endif
            end else begin
              word <= merged;
              if (last_byte) begin
                state      <= S_RX_WRITE;
                wram       <= 1'b1;
                ramaddress <= rx_addr;
                wramdata   <= merged;
              end else begin
                state    <= S_IDLE;
                byte_cnt <= byte_cnt + 1'b1;
              end
            end
          end
        end

        S_RX_WRITE: begin
          state    <= S_IDLE;
          rx_addr  <= rx_addr + 1'b1;
          byte_cnt <= '0;
        end

        S_TX_FETCH: begin
          if ((byte_cnt == '0) && (rramdata == '0)) begin
            state    <= S_CLEAR;
            rx_addr  <= ADDR_W'(RX_BASE);
            wram     <= 1'b1;
            wramdata <= '0;
          end else begin
            state    <= S_TX_BIT;
            datao    <= 1'b0;
            tx_shift <= tx_frame >> 1;
            bit_cnt  <= '0;
          end
        end

        S_TX_BIT: begin
          if (full_tick) begin
            if (bit_cnt == 4'(FRAME_BITS - 1)) begin
              state <= S_TX_FETCH;
              if (last_byte) begin
                tx_addr    <= tx_addr + 1'b1;
                byte_cnt   <= '0;
                ramaddress <= tx_addr + 1'b1;
              end else begin
                byte_cnt   <= byte_cnt + 1'b1;
                ramaddress <= tx_addr;
              end
            end else begin
              datao    <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end else begin
            datao <= datao;
          end
        end

        S_CLEAR: begin
          state <= S_IDLE;
        end

        S_EXCEPTION: begin
          state    <= S_CLEAR;
          word     <= '0;
          byte_cnt <= '0;
          wram     <= 1'b1;
          wramdata <= '0;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_ram_bridge.sv
// ============================================================================
// tb_uart_ram_bridge : directed self-checking bench for uart_ram_bridge
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_uart_ram_bridge;
  import uart_bridge_pkg::*;

  localparam int          CPB  = 4;
  localparam logic [31:0] RXB  = 32'd206800;
  localparam logic [31:0] CTRL = 32'd411699;
  localparam logic [31:0] EXC  = 32'd411698;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        datai = 1'b1;
  logic [31:0] rramdata;
  logic        datao;
  logic        wram;
  logic [31:0] ramaddress;
  logic [31:0] wramdata;
  logic        busy;

  always #5 clk = ~clk;

  uart_ram_bridge #(
    .CLKS_PER_BIT (4),
    .WORD_BYTES   (4),
    .ADDR_W       (32),
    .RX_BASE      (206800),
    .CTRL_ADDR    (411699),
    .EXC_ADDR     (411698),
    .IDLE_TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .datai      (datai),
    .rramdata   (rramdata),
    .datao      (datao),
    .wram       (wram),
    .ramaddress (ramaddress),
    .wramdata   (wramdata),
    .busy       (busy)
  );

  // Sparse RAM model: control word, exception word and 16 data words.
  logic [31:0] ctrl_word = 32'd0;
  logic [31:0] exc_word  = 32'd0;
  logic [31:0] data_mem [16] = '{default: 32'd0};
  logic        tb_we   = 1'b0;
  logic [31:0] tb_addr = 32'd0;
  logic [31:0] tb_data = 32'd0;
  logic [31:0] wa, wd, woff, roff;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t wlog [64];
  int  wr_n = 0;

  assign wa   = wram ? ramaddress : tb_addr;
  assign wd   = wram ? wramdata   : tb_data;
  assign woff = wa - RXB;

  always @(posedge clk) begin
    if (wram && wr_n < 64) begin
      wlog[wr_n] <= '{a: ramaddress, d: wramdata};
      wr_n       <= wr_n + 1;
    end
    if (wram || tb_we) begin
      if (wa == CTRL)       ctrl_word <= wd;
      else if (wa == EXC)   exc_word  <= wd;
      else if (woff < 16)   data_mem[woff[3:0]] <= wd;
    end
  end

  always_comb begin
    rramdata = 32'd0;
    roff     = ramaddress - RXB;
    if (ramaddress == CTRL)     rramdata = ctrl_word;
    else if (ramaddress == EXC) rramdata = exc_word;
    else if (roff < 16)         rramdata = data_mem[roff[3:0]];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    datai = v;
    tick(CPB);
  endtask

`ifdef UART_PARITY_CHECK_EN
  logic bad_par = 1'b0;
`endif

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_PARITY_CHECK_EN
    send_bit((^b) ^ bad_par);
`endif
    send_bit(stop_v);
    datai = 1'b1;
  endtask

  task automatic mem_write(input logic [31:0] a, input logic [31:0] d);
    tb_addr = a;
    tb_data = d;
    tb_we   = 1'b1;
    tick(1);
    tb_we   = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] b, output bit ok);
    ok = 1'b0;
    b  = 8'h00;
    for (int i = 0; i < 150; i++) begin
      if (datao === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    if (ok) begin
      tick(CPB / 2);
      if (datao !== 1'b0) ok = 1'b0;
      for (int j = 0; j < 8; j++) begin
        tick(CPB);
        b[j] = datao;
      end
`ifdef UART_PARITY_CHECK_EN
      tick(CPB);
      if (datao !== ^b) ok = 1'b0;
`endif
      tick(CPB);
      if (datao !== 1'b1) ok = 1'b0;
    end
  endtask

  typedef struct {
    logic [7:0]  b [4];
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;
  vec_t vt [3];

  initial begin
    int         base;
    logic [7:0] rb;
    bit         ok;
    logic [7:0] txexp [4];

    vt[0].b = '{8'h12, 8'h34, 8'h56, 8'h78}; vt[0].addr = RXB;     vt[0].data = 32'h12345678;
    vt[1].b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF}; vt[1].addr = RXB + 1; vt[1].data = 32'hDEADBEEF;
    vt[2].b = '{8'h00, 8'hFF, 8'h01, 8'h80}; vt[2].addr = RXB + 2; vt[2].data = 32'h00FF0180;
    txexp   = '{8'hA5, 8'h00, 8'h00, 8'h01};

    tick(3);
    check("reset_datao", datao, 1);
    check("reset_wram", wram, 0);
    check("reset_ramaddress", ramaddress, CTRL);
    check("reset_wramdata", wramdata, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    tick(2);

    for (int v = 0; v < 3; v++) begin
      base = wr_n;
      for (int k = 0; k < 4; k++) send_byte(vt[v].b[k], 1'b1);
      tick(3);
      check("rx_word_count", 64'(wr_n - base), 1);
      check("rx_word_addr", wlog[base].a, vt[v].addr);
      check("rx_word_data", wlog[base].d, vt[v].data);
    end

    // One-cycle glitch on the line: a false start.
    base  = wr_n;
    datai = 1'b0;
    tick(1);
    datai = 1'b1;
    check("false_start_busy_hi", busy, 1);
    tick(2);
    check("false_start_busy_lo", busy, 0);
    tick(8);
    check("false_start_no_write", 64'(wr_n - base), 0);

    // Bad stop bit.
    base = wr_n;
    send_byte(8'h55, 1'b0);
    tick(4);
    check("stop_err_count", 64'(wr_n - base), 2);
    check("stop_err_exc_addr", wlog[base].a, EXC);
    check("stop_err_exc_code", wlog[base].d, 1);
    check("stop_err_clr_addr", wlog[base + 1].a, CTRL);
    check("stop_err_clr_data", wlog[base + 1].d, 0);

    // Partial word followed by an idle line.
    base = wr_n;
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    tick(40);
    check("timeout_not_early", 64'(wr_n - base), 0);
    tick(40);
    check("timeout_count", 64'(wr_n - base), 2);
    check("timeout_exc_addr", wlog[base].a, EXC);
    check("timeout_exc_code", wlog[base].d, 3);
    check("timeout_clr_addr", wlog[base + 1].a, CTRL);
    base = wr_n;
    for (int k = 0; k < 4; k++) send_byte(8'h11 * 8'(k + 1), 1'b1);
    tick(3);
    check("after_timeout_addr", wlog[base].a, RXB + 3);
    check("after_timeout_data", wlog[base].d, 32'h11223344);

    // CPU-requested transmit.
    mem_write(RXB, 32'hA5000001);
    mem_write(RXB + 1, 32'h0);
    base = wr_n;
    mem_write(CTRL, 32'd1);
    for (int k = 0; k < 4; k++) begin
      recv_byte(rb, ok);
      check("tx_frame_ok", ok, 1);
      check("tx_byte", rb, txexp[k]);
    end
    for (int i = 0; i < 100 && busy !== 1'b0; i++) tick(1);
    check("tx_busy_drop", busy, 0);
    check("tx_clr_count", 64'(wr_n - base), 1);
    check("tx_clr_addr", wlog[base].a, CTRL);
    check("tx_ctrl_cleared", ctrl_word, 0);

    // Transmit completion rewinds the receive address.
    base = wr_n;
    for (int k = 0; k < 4; k++) send_byte(8'hC0 + 8'(k), 1'b1);
    tick(3);
    check("rewind_addr", wlog[base].a, RXB);
    check("rewind_data", wlog[base].d, 32'hC0C1C2C3);

`ifdef UART_PARITY_CHECK_EN
    base    = wr_n;
    bad_par = 1'b1;
    send_byte(8'h01, 1'b1);
    bad_par = 1'b0;
    tick(4);
    check("parity_count", 64'(wr_n - base), 2);
    check("parity_exc_addr", wlog[base].a, EXC);
    check("parity_exc_code", wlog[base].d, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
